// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline front end (PC, Fetch/Decode, Decode/Execute).
// Optional stall-cycle performance counter: define STALL_PERF_COUNTER_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter logic [4:0]  ZERO_REG     = 5'd31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rn_Decode,
  input  logic [4:0] Rm_Decode,
  input  logic       useRn_Decode,
  input  logic       useRm_Decode,
  input  logic [4:0] Rd_DecodeRegister,
  input  logic       MemToReg_DecodeRegister,
  input  logic       RegWrite_DecodeRegister,
  input  logic       branchTaken_Execute,
  input  logic       memBusy,
  output logic       pcEnable,
  output logic       fetchRegEnable,
  output logic       decodeRegEnable,
  output logic       decodeBubble,
  output logic       fetchFlush,
  output logic       memTimeout,
`ifdef STALL_PERF_COUNTER_EN
  input  logic       perfClear,
  output logic [31:0] stallCycles,
`endif
  output logic [1:0] hazardState
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX     = 8'(MEM_TIMEOUT);
  localparam logic [7:0] WAIT_LAST    = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [2:0] flush_cnt;
  logic [7:0] wait_cnt;
  logic       load_use;

  assign load_use = MemToReg_DecodeRegister & RegWrite_DecodeRegister &
                    (Rd_DecodeRegister != ZERO_REG) &
                    ((useRn_Decode & (Rn_Decode == Rd_DecodeRegister)) |
                     (useRm_Decode & (Rm_Decode == Rd_DecodeRegister)));

  // Control vector order: pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush.
  always_comb begin
    {pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush} = 5'b00011;
    hazardState = 2'd0;
    if (reset) begin
      hazardState = state;
      case (state)
        RUN: begin
          if (memBusy)
            {pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush} = 5'b00000;
          else if (branchTaken_Execute)
            {pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush} = 5'b11111;
          else if (load_use)
            {pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush} = 5'b00110;
          else
            {pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush} = 5'b11100;
        end
        MEM_WAIT:
          {pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush} = 5'b00000;
        FLUSH: begin
          if (memBusy)
            {pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush} = 5'b00000;
          else
            {pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush} = 5'b11111;
        end
        default:
          {pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush} = 5'b11100;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      flush_cnt  <= '0;
      wait_cnt   <= '0;
      memTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memBusy) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end else if (branchTaken_Execute && (FLUSH_CYCLES > 1)) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_RELOAD;
          end
        end
        MEM_WAIT: begin
          if (memBusy) begin
            if (wait_cnt == WAIT_LAST)
              memTimeout <= 1'b1;
            if (wait_cnt != WAIT_MAX)
              wait_cnt <= wait_cnt + 8'd1;
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        FLUSH: begin
          if (memBusy) begin
            state     <= MEM_WAIT;
            wait_cnt  <= 8'd1;
            flush_cnt <= '0;
          end else if (branchTaken_Execute) begin
            flush_cnt <= FLUSH_RELOAD;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
            if (flush_cnt == 3'd1)
              state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef STALL_PERF_COUNTER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stallCycles <= '0;
    else if (perfClear)
      stallCycles <= '0;
    else if (!pcEnable)
      stallCycles <= stallCycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int FC = 2;
  localparam int MT = 16;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rn_Decode, Rm_Decode, Rd_DecodeRegister;
  logic useRn_Decode, useRm_Decode, MemToReg_DecodeRegister, RegWrite_DecodeRegister;
  logic branchTaken_Execute, memBusy;
  logic pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush, memTimeout;
  logic [1:0] hazardState;
`ifdef STALL_PERF_COUNTER_EN
  logic perfClear;
  logic [31:0] stallCycles;
`endif

  int total = 0;
  int bad = 0;

  // Model: frozen-for-memory flag, flush cycles still owed, consecutive busy cycles, sticky timeout.
  bit          m_wait;
  int          m_flush_left;
  int          m_run;
  bit          m_to;
  logic [31:0] m_stall;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .ZERO_REG(5'd31)) dut (
    .clk(clk), .reset(reset),
    .Rn_Decode(Rn_Decode), .Rm_Decode(Rm_Decode),
    .useRn_Decode(useRn_Decode), .useRm_Decode(useRm_Decode),
    .Rd_DecodeRegister(Rd_DecodeRegister),
    .MemToReg_DecodeRegister(MemToReg_DecodeRegister),
    .RegWrite_DecodeRegister(RegWrite_DecodeRegister),
    .branchTaken_Execute(branchTaken_Execute), .memBusy(memBusy),
    .pcEnable(pcEnable), .fetchRegEnable(fetchRegEnable), .decodeRegEnable(decodeRegEnable),
    .decodeBubble(decodeBubble), .fetchFlush(fetchFlush), .memTimeout(memTimeout),
`ifdef STALL_PERF_COUNTER_EN
    .perfClear(perfClear), .stallCycles(stallCycles),
`endif
    .hazardState(hazardState)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_vec();
    return {pcEnable, fetchRegEnable, decodeRegEnable, decodeBubble, fetchFlush, memTimeout, hazardState};
  endfunction

  function automatic bit hazard();
    return MemToReg_DecodeRegister && RegWrite_DecodeRegister && (Rd_DecodeRegister != 5'd31) &&
           ((useRn_Decode && Rn_Decode == Rd_DecodeRegister) ||
            (useRm_Decode && Rm_Decode == Rd_DecodeRegister));
  endfunction

  function automatic logic [7:0] exp_out();
    logic [4:0] c;
    logic [1:0] hs;
    if (!reset) return 8'b00011_0_00;
    hs = m_wait ? 2'd1 : (m_flush_left > 0 ? 2'd2 : 2'd0);
    if (m_wait || memBusy)                     c = 5'b00000;
    else if (branchTaken_Execute || m_flush_left > 0) c = 5'b11111;
    else if (hazard())                         c = 5'b00110;
    else                                       c = 5'b11100;
    return {c, m_to, hs};
  endfunction

  task automatic idle();
    Rn_Decode = 5'd0; Rm_Decode = 5'd0; Rd_DecodeRegister = 5'd0;
    useRn_Decode = 1'b0; useRm_Decode = 1'b0;
    MemToReg_DecodeRegister = 1'b0; RegWrite_DecodeRegister = 1'b0;
    branchTaken_Execute = 1'b0; memBusy = 1'b0;
`ifdef STALL_PERF_COUNTER_EN
    perfClear = 1'b0;
`endif
  endtask

  task automatic randomize_inputs();
    Rn_Decode = 5'($urandom); Rm_Decode = 5'($urandom); Rd_DecodeRegister = 5'($urandom);
    useRn_Decode = 1'($urandom); useRm_Decode = 1'($urandom);
    MemToReg_DecodeRegister = 1'($urandom); RegWrite_DecodeRegister = 1'($urandom);
    branchTaken_Execute = 1'($urandom); memBusy = 1'($urandom);
  endtask

  // Advance model and DUT by one clock; inputs are held across the edge.
  task automatic step();
    logic [7:0] e;
    e = exp_out();
    @(posedge clk);
    if (!reset) begin
      m_wait = 0; m_flush_left = 0; m_run = 0; m_to = 0; m_stall = '0;
    end else begin
`ifdef STALL_PERF_COUNTER_EN
      if (perfClear) m_stall = '0;
      else if (!e[7]) m_stall = m_stall + 32'd1;
`endif
      if (memBusy) begin
        m_run++;
        if (m_run >= MT) m_to = 1;
        m_wait = 1;
        m_flush_left = 0;
      end else if (m_wait) begin
        m_wait = 0;
        m_run = 0;
      end else begin
        m_run = 0;
        if (branchTaken_Execute) m_flush_left = FC - 1;
        else if (m_flush_left > 0) m_flush_left--;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] got, e;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      #2; got = dut_vec(); e = exp_out(); total++;
      if (got !== e || got !== 8'b00011_0_00) begin
        bad++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, got, e);
      end
      step();
    end
    idle();
    reset = 1'b1;
    step();
    #2; got = dut_vec(); total++;
    if (got[7:5] !== 3'b111 || got !== exp_out()) begin
      bad++; $display("FAIL reset_release got=%b exp=%b", got, exp_out());
    end
    step();
  endtask

  task automatic test_load_use();
    logic [7:0] got, e;
    int stalls;
    for (int pass = 0; pass < 2; pass++) begin
      idle();
      stalls = 0;
      MemToReg_DecodeRegister = 1'b1; RegWrite_DecodeRegister = 1'b1;
      Rd_DecodeRegister = (pass == 0) ? 5'd5 : 5'd31;
      Rm_Decode = Rd_DecodeRegister; useRm_Decode = 1'b1;
      #2; got = dut_vec(); e = exp_out(); total++;
      if (got !== e) begin
        bad++; $display("FAIL load_use pass=%0d got=%b exp=%b", pass, got, e);
      end
      if (got[7] === 1'b0) stalls++;
      step();
      idle();
      #2; got = dut_vec(); e = exp_out(); total++;
      if (got !== e) begin
        bad++; $display("FAIL load_use_after pass=%0d got=%b exp=%b", pass, got, e);
      end
      if (got[7] === 1'b0) stalls++;
      total++;
      if (stalls != ((pass == 0) ? 1 : 0)) begin
        bad++; $display("FAIL load_use_count pass=%0d got=%0d exp=%0d", pass, stalls, (pass == 0) ? 1 : 0);
      end
      step();
    end
  endtask

  task automatic test_branch();
    logic [7:0] got, e;
    logic [1:0] hs_exp [3] = '{2'd0, 2'd2, 2'd0};
    logic       fl_exp [3] = '{1'b1, 1'b1, 1'b0};
    idle();
    for (int i = 0; i < 3; i++) begin
      branchTaken_Execute = (i == 0);
      #2; got = dut_vec(); e = exp_out(); total++;
      if (got !== e || got[1:0] !== hs_exp[i] || got[3] !== fl_exp[i]) begin
        bad++; $display("FAIL branch cyc=%0d got=%b exp=%b", i, got, e);
      end
      step();
    end
  endtask

  task automatic test_mem_short();
    logic [7:0] got, e;
    idle();
    for (int i = 1; i <= 6; i++) begin
      memBusy = (i <= 4);
      #2; got = dut_vec(); e = exp_out(); total++;
      if (got !== e || got[2] !== 1'b0 || (i <= 4 && got[7:5] !== 3'b000)) begin
        bad++; $display("FAIL mem_short cyc=%0d got=%b exp=%b", i, got, e);
      end
      step();
    end
  endtask

  task automatic test_mem_timeout();
    logic [7:0] got, e;
    idle();
    for (int i = 1; i <= 24; i++) begin
      memBusy = (i <= 20);
      #2; got = dut_vec(); e = exp_out(); total++;
      if (got !== e || got[2] !== (i > MT)) begin
        bad++; $display("FAIL mem_timeout cyc=%0d got=%b exp=%b", i, got, e);
      end
      step();
    end
    reset = 1'b0;
    #2; total++;
    if (memTimeout !== 1'b0) begin
      bad++; $display("FAIL timeout_clear got=%b exp=0", memTimeout);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_combined();
    logic [7:0] got, e;
    idle();
    MemToReg_DecodeRegister = 1'b1; RegWrite_DecodeRegister = 1'b1;
    Rd_DecodeRegister = 5'd9; Rn_Decode = 5'd9; useRn_Decode = 1'b1;
    branchTaken_Execute = 1'b1;
    for (int i = 0; i < 4; i++) begin
      memBusy = (i < 3);
      #2; got = dut_vec(); e = exp_out(); total++;
      if (got !== e || (i < 3 && got[7:3] !== 5'b00000)) begin
        bad++; $display("FAIL combined cyc=%0d got=%b exp=%b", i, got, e);
      end
`ifdef STALL_PERF_COUNTER_EN
      total++;
      if (stallCycles !== m_stall) begin
        bad++; $display("FAIL combined_stall cyc=%0d got=%0d exp=%0d", i, stallCycles, m_stall);
      end
`endif
      step();
    end
    idle();
    step();
  endtask

  task automatic test_random();
    logic [7:0] got, e;
    int burst = 0;
    logic [4:0] regs [4] = '{5'd3, 5'd5, 5'd7, 5'd31};
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      Rn_Decode = regs[$urandom_range(0, 3)]; Rm_Decode = regs[$urandom_range(0, 3)];
      Rd_DecodeRegister = regs[$urandom_range(0, 3)];
      useRn_Decode = 1'($urandom); useRm_Decode = 1'($urandom);
      MemToReg_DecodeRegister = 1'($urandom); RegWrite_DecodeRegister = 1'($urandom);
      branchTaken_Execute = ($urandom_range(0, 99) < 15);
      if (burst > 0) burst--;
      else if ($urandom_range(0, 99) < 8) burst = $urandom_range(1, 20);
      memBusy = (burst > 0);
`ifdef STALL_PERF_COUNTER_EN
      perfClear = ($urandom_range(0, 99) < 3);
`endif
      #2; got = dut_vec(); e = exp_out(); total++;
      if (got !== e) begin
        bad++; $display("FAIL random cyc=%0d got=%b exp=%b", i, got, e);
      end
`ifdef STALL_PERF_COUNTER_EN
      total++;
      if (stallCycles !== m_stall) begin
        bad++; $display("FAIL random_stall cyc=%0d got=%0d exp=%0d", i, stallCycles, m_stall);
      end
`endif
      step();
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    m_wait = 0; m_flush_left = 0; m_run = 0; m_to = 0; m_stall = '0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_mem_short();
    test_mem_timeout();
    test_combined();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
